ice40_spram_wb_vga_burst: RTL

Parametrised SPRAM memory for the SoC: BANKS × 32 KiB built from iCE40 SB_SPRAM256KA blocks. It serves a pipelined Wishbone port of selectable width and a video burst port with priority. Unlike the single-word video stall scheme, video fetches run as fixed-length bursts of consecutive 16-bit words, each delivered with a valid strobe. Wishbone stalls only while a burst owns the RAM. The block sits between the CPU bus interconnect and the VGA scan-out FIFO.

---
 rtl/ice40_spram_wb_vga_burst_pkg.sv | 23 ++
 rtl/ice40_spram_wb_vga_burst_bank.sv | 42 ++++
 rtl/ice40_spram_wb_vga_burst.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ice40_spram_wb_vga_burst_pkg.sv
// Shared SPRAM bank geometry, burst FSM states and parameter legality check
// for the Wishbone/VGA-burst SPRAM block.
package ice40_spram_wb_vga_burst_pkg;

    localparam int unsigned SPRAM_ROWS   = 16384;
    localparam int unsigned SPRAM_WIDTH  = 16;
    localparam int unsigned SPRAM_ROW_AW = 14;
    localparam int unsigned SPRAM_MASK_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic bit cfg_legal(input int unsigned banks,
                                     input int unsigned wb_width,
                                     input int unsigned burst);
        return ((banks == 2) || (banks == 4)) &&
               ((wb_width == 8) || (wb_width == 16)) &&
               (burst >= 1) && (burst <= 16);
    endfunction

endpackage

// File: rtl/ice40_spram_wb_vga_burst_bank.sv
// One 16K x 16 SPRAM bank with SB_SPRAM256KA port behaviour: nibble write mask,
// registered read data that holds its value when the bank is not read.
module ice40_spram_bank
    import ice40_spram_wb_vga_burst_pkg::*;
(
    input  logic                    clk,
    input  logic [SPRAM_ROW_AW-1:0] addr,
    input  logic [SPRAM_WIDTH-1:0]  din,
    input  logic [SPRAM_MASK_W-1:0] maskwren,
    input  logic                    wren,
    input  logic                    cs,
    output logic [SPRAM_WIDTH-1:0]  dout
);

    // Power pins are tied: never in standby or sleep, never powered off (POWEROFF is active-low).
    logic standby;
    logic sleep;
    logic poweroff;
    logic active;

    assign standby  = 1'b0;
    assign sleep    = 1'b0;
    assign poweroff = 1'b1;
    assign active   = cs & ~standby & ~sleep & poweroff;

    logic [SPRAM_WIDTH-1:0] mem [SPRAM_ROWS];

    always_ff @(posedge clk) begin
        if (active) begin
            if (wren) begin
                for (int unsigned n = 0; n < SPRAM_MASK_W; n++) begin
                    if (maskwren[n]) begin
                        mem[addr][n*4 +: 4] <= din[n*4 +: 4];
                    end
                end
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ice40_spram_wb_vga_burst.sv
// BANKS x 32 KiB SPRAM shared by a pipelined Wishbone port and a prioritised
// video port that fetches fixed-length bursts of consecutive 16-bit words.
module ice40_spram_wb_vga_burst
    import ice40_spram_wb_vga_burst_pkg::*;
#(
    parameter int unsigned BANKS    = 4,
    parameter int unsigned WB_WIDTH = 8,
    parameter int unsigned BURST    = 4,
    parameter int unsigned AW       = $clog2(BANKS * 32768 / (WB_WIDTH / 8)),
    parameter int unsigned VAW      = $clog2(BANKS * 16384)
) (
    input  logic                  I_wb_clk,
    input  logic                  I_reset_n,
    input  logic                  I_wb_stb,
    input  logic                  I_wb_we,
    input  logic [AW-1:0]         I_wb_adr,
    input  logic [WB_WIDTH/8-1:0] I_wb_sel,
    input  logic [WB_WIDTH-1:0]   I_wb_dat,
    output logic [WB_WIDTH-1:0]   O_wb_dat,
    output logic                  O_wb_ack,
    output logic                  O_wb_stall,
    input  logic                  I_vga_req,
    input  logic [VAW-1:0]        I_vga_adr,
    output logic                  O_vga_busy,
    output logic                  O_vga_valid,
    output logic [15:0]           O_vga_dat
);

    localparam int unsigned BB = $clog2(BANKS);
    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;

    if (!cfg_legal(BANKS, WB_WIDTH, BURST)) begin : g_bad_cfg
        $error("ice40_spram_wb_vga_burst: unsupported BANKS/WB_WIDTH/BURST");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [VAW-1:0]          vga_adr_q;
    logic [CW-1:0]           count_q;
    logic                    load_burst;
    logic                    wb_accept;
    logic                    wb_ack_q;
    logic                    vga_valid_q;

    logic [VAW-1:0]          wb_word;
    logic [VAW-1:0]          issue_word;
    logic [BB-1:0]           issue_bank;
    logic [SPRAM_ROW_AW-1:0] issue_row;
    logic                    issue_rd;
    logic                    issue_wr;
    logic [BB-1:0]           rd_bank_q;
    logic [SPRAM_WIDTH-1:0]  wr_data;
    logic [SPRAM_MASK_W-1:0] wr_mask;
    logic                    wr_gate;
    logic [SPRAM_WIDTH-1:0]  rd_data;
    logic [BANKS-1:0]        cs;
    logic [SPRAM_WIDTH-1:0]  bank_dout [BANKS];

    always_comb begin
        state_d    = state_q;
        load_burst = 1'b0;
        wb_accept  = 1'b0;
        O_wb_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_vga_req) begin
                    state_d    = ST_BURST;
                    load_burst = 1'b1;
                    O_wb_stall = 1'b1;
                end else begin
                    wb_accept = I_wb_stb;
                end
            end
            ST_BURST: begin
                O_wb_stall = 1'b1;
                if (count_q == CW'(BURST - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_bank = issue_word[BB-1:0];
    assign issue_row  = issue_word[VAW-1:BB];

    always_comb begin
        issue_word = (state_q == ST_BURST) ? vga_adr_q : wb_word;
        issue_rd   = (state_q == ST_BURST) | (wb_accept & ~I_wb_we);
        issue_wr   = wb_accept & I_wb_we & wr_gate;
        cs         = '0;
        // Reset also closes the RAM port so a bus write held across reset cannot land.
        for (int unsigned b = 0; b < BANKS; b++) begin
            cs[b] = I_reset_n & (issue_rd | issue_wr) & (issue_bank == BB'(b));
        end
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q     <= ST_IDLE;
            vga_adr_q   <= '0;
            count_q     <= '0;
            wb_ack_q    <= 1'b0;
            vga_valid_q <= 1'b0;
            rd_bank_q   <= '0;
        end else begin
            state_q     <= state_d;
            wb_ack_q    <= wb_accept;
            vga_valid_q <= (state_q == ST_BURST);
            if (load_burst) begin
                vga_adr_q <= I_vga_adr;
                count_q   <= '0;
            end else if (state_q == ST_BURST) begin
                vga_adr_q <= vga_adr_q + VAW'(1);
                count_q   <= count_q + CW'(1);
            end
            if (issue_rd) begin
                rd_bank_q <= issue_bank;
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ice40_spram_bank u_bank (
            .clk      (I_wb_clk),
            .addr     (issue_row),
            .din      (wr_data),
            .maskwren (wr_mask),
            .wren     (issue_wr),
            .cs       (cs[b]),
            .dout     (bank_dout[b])
        );
    end

    assign rd_data = bank_dout[rd_bank_q];

    if (WB_WIDTH == 8) begin : g_wb8
        logic lane_q;

        assign wb_word = I_wb_adr[AW-1:1];
        assign wr_data = {I_wb_dat, I_wb_dat};
        assign wr_mask = I_wb_adr[0] ? 4'b1100 : 4'b0011;
        assign wr_gate = I_wb_sel[0];

        always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
            if (!I_reset_n) begin
                lane_q <= 1'b0;
            end else if (wb_accept & ~I_wb_we) begin
                lane_q <= I_wb_adr[0];
            end
        end

        assign O_wb_dat = lane_q ? rd_data[15:8] : rd_data[7:0];
    end else begin : g_wb16
        assign wb_word  = I_wb_adr;
        assign wr_data  = I_wb_dat;
        assign wr_mask  = {I_wb_sel[1], I_wb_sel[1], I_wb_sel[0], I_wb_sel[0]};
        assign wr_gate  = 1'b1;
        assign O_wb_dat = rd_data;
    end

    // Video port presents bytes in address order: even byte high, odd byte low.
    assign O_vga_dat   = {rd_data[7:0], rd_data[15:8]};
    assign O_vga_valid = vga_valid_q;
    assign O_vga_busy  = (state_q == ST_BURST);
    assign O_wb_ack    = wb_ack_q;

endmodule
